// File: rtl/boundary_pkg.sv
// Shared types and helpers for the scrolling river-boundary row buffer.
// Holds the controller state encoding, default geometry and modular index increment.
package boundary_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 40;
    localparam int DEFAULT_DEPTH = 480;

    // Increment modulo depth; depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx >= depth - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/boundary_ram.sv
// Simple dual-port row memory: one write port, one registered read port.
// Kept free of reset and control logic so it maps onto block RAM.
module boundary_ram
    import boundary_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch; a reset would block RAM inference. Clearing is done by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        // NOTE: non-blocking assignments here give read-before-write, so a same-slot collision returns old data.
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scroll_boundary_buf.sv
// Circular scanline boundary buffer: logical line 0 sits at physical slot base,
// scrolling advances base one row per accepted write beat.
module scroll_boundary_buf
    import boundary_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               DEPTH       = DEFAULT_DEPTH,
    parameter int               AMT_W       = 4,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int              ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_req,
    input  logic [AMT_W-1:0]  shift_amt,
    output logic              busy,
    output logic              shift_drop,
    input  logic              wr_valid,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] base
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [AMT_W-1:0]  remaining;

    logic [ADDR_W:0]   rd_sum;
    logic [ADDR_W-1:0] rd_phys;
    logic              rd_in_range;
    logic              rd_from_ram;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WIDTH-1:0]  ram_wdata;
    logic [WIDTH-1:0]  ram_rdata;

    // Both operands are below DEPTH, so one conditional subtract completes the wrap.
    always_comb begin
        rd_sum      = {1'b0, base} + {1'b0, rd_addr};
        rd_phys     = (rd_sum >= DEPTH_EXT) ? ADDR_W'(rd_sum - DEPTH_EXT) : rd_sum[ADDR_W-1:0];
        rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        ram_we    = 1'b0;
        ram_waddr = base;
        ram_wdata = wr_data;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = CLEAR_VALUE;
            end
            ST_FILL:  ram_we = wr_valid;
            default:  ;
        endcase
    end

    boundary_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_en && rd_in_range),
        .raddr (rd_phys),
        .rdata (ram_rdata)
    );

    // Scroll controller; busy and wr_ready are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            remaining  <= '0;
            base       <= '0;
            busy       <= 1'b1;
            wr_ready   <= 1'b0;
            shift_drop <= 1'b0;
        end else begin
            shift_drop <= shift_req && busy;
            case (state)
                ST_CLEAR: begin
                    if (clr_cnt == LAST_SLOT) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (shift_req && (shift_amt != '0)) begin
                        remaining <= shift_amt;
                        state     <= ST_FILL;
                        busy      <= 1'b1;
                        wr_ready  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (wr_valid) begin
                        base      <= ADDR_W'(wrap_inc(32'(base), unsigned'(DEPTH)));
                        remaining <= remaining - 1'b1;
                        if (remaining == AMT_W'(1)) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            wr_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_CLEAR;
                    clr_cnt  <= '0;
                    busy     <= 1'b1;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    // Out-of-range reads skip the RAM and return the clear value instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            rd_from_ram <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_from_ram <= rd_in_range;
            end
        end
    end

    assign rd_data = rd_from_ram ? ram_rdata : CLEAR_VALUE;

endmodule
